// File: rtl/fp_divider.sv
// Iterative IEEE-754 divider (N=32 or 64): one restoring-division quotient bit per clock.
// Denormals flush to zero, results truncate, start/done handshake with busy.
module fp_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Result,
  output logic         busy,
  output logic         done
);
  localparam int M    = (N == 64) ? 52 : 23;
  localparam int E    = (N == 64) ? 11 : 8;
  localparam int BIAS = (N == 64) ? 1023 : 127;
  localparam int CW   = $clog2(M + 2);
  localparam logic [E+1:0]        BIAS_W = (E + 2)'(BIAS);
  localparam logic signed [E+1:0] EMAX   = {2'b00, {E{1'b1}}};
  localparam logic [N-1:0]        NAN_V  = {1'b0, {E{1'b1}}, {M{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t         r_state;
  logic [N-1:0]   r_a, r_b, r_result;
  logic [M+1:0]   r_rem, r_q;
  logic [CW-1:0]  r_cnt;
  logic           r_busy, r_done;

  logic [E-1:0]   w_ea, w_eb;
  logic [M-1:0]   w_ma, w_mb;
  logic           w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan, w_sign;
  logic           w_special, w_ge;
  logic [N-1:0]   w_spec_val, w_norm_val;
  logic [M+1:0]   w_div, w_sub, w_rem_next;
  logic signed [E+1:0] w_exp;
  logic [M-1:0]   w_mant;

  assign w_ea     = r_a[N-2:M];
  assign w_eb     = r_b[N-2:M];
  assign w_ma     = r_a[M-1:0];
  assign w_mb     = r_b[M-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_ma == '0);
  assign w_b_inf  = (&w_eb) && (w_mb == '0);
  assign w_a_nan  = (&w_ea) && (|w_ma);
  assign w_b_nan  = (&w_eb) && (|w_mb);
  assign w_sign   = r_a[N-1] ^ r_b[N-1];

  always_comb begin
    w_special  = 1'b1;
    w_spec_val = '0;
    if (w_a_nan || w_b_nan)          w_spec_val = NAN_V;
    else if (w_a_inf && w_b_inf)     w_spec_val = NAN_V;
    else if (w_a_zero && w_b_zero)   w_spec_val = NAN_V;
    else if (w_a_inf)                w_spec_val = {w_sign, {E{1'b1}}, {M{1'b0}}};
    else if (w_b_inf)                w_spec_val = '0;
    else if (w_b_zero)               w_spec_val = {w_sign, {E{1'b1}}, {M{1'b0}}};
    else if (w_a_zero)               w_spec_val = '0;
    else                             w_special  = 1'b0;
  end

  // Restoring step: the remainder always stays below 2*divisor, so M+2 bits suffice.
  assign w_div      = {1'b0, 1'b1, w_mb};
  assign w_ge       = (r_rem >= w_div);
  assign w_sub      = w_ge ? (r_rem - w_div) : r_rem;
  assign w_rem_next = w_sub << 1;

  assign w_exp  = {2'b00, w_ea} - {2'b00, w_eb} + BIAS_W - {{(E+1){1'b0}}, ~r_q[M+1]};
  assign w_mant = r_q[M+1] ? r_q[M:1] : r_q[M-1:0];

  always_comb begin
    if (w_exp >= EMAX)        w_norm_val = {w_sign, {E{1'b1}}, {M{1'b0}}};
    else if (w_exp <= 0)      w_norm_val = '0;
    else                      w_norm_val = {w_sign, w_exp[E-1:0], w_mant};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_special) begin
            r_result <= w_spec_val;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_rem   <= {1'b0, 1'b1, w_ma};
            r_q     <= '0;
            r_cnt   <= CW'(M + 1);
            r_state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[M:0], w_ge};
          if (r_cnt == '0) r_state <= S_NORM;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_NORM: begin
          r_result <= w_norm_val;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed cases, handshake/reset scenarios and random single-precision
// operands checked against an integer-division reference model.
module tb_fp_divider;
  logic        clk = 1'b0;
  logic        rst, start, start64;
  logic [31:0] a, b, result;
  logic [63:0] a64, b64, result64;
  logic        busy, done, busy64, done64;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  fp_divider #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .Result(result), .busy(busy), .done(done)
  );

  fp_divider #(.N(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .A(a64), .B(b64),
    .Result(result64), .busy(busy64), .done(done64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: classify, then quotient = floor(1.mA * 2^24 / 1.mB), truncate, bias and clamp.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          output bit special);
    int ex, ey, e;
    logic [63:0] q, nx, ny;
    logic s, xz, yz, xi, yi, xn, yn;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0); yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0); yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0); yn = (ey == 255) && (y[22:0] != 0);
    special = 1'b1;
    if (xn || yn || (xi && yi) || (xz && yz)) return 32'h7FFFFFFF;
    if (xi) return {s, 8'hFF, 23'h0};
    if (yi) return 32'h0;
    if (yz) return {s, 8'hFF, 23'h0};
    if (xz) return 32'h0;
    special = 1'b0;
    nx = 64'(x[22:0]) + 64'h800000;
    ny = 64'(y[22:0]) + 64'h800000;
    q  = (nx << 24) / ny;
    if (q >= 64'h1000000) e = ex - ey + 127;
    else                  e = ex - ey + 126;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return 32'h0;
    if (q >= 64'h1000000) return {s, e[7:0], q[23:1]};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    int k;
    k = $urandom_range(0, 9);
    v = $urandom;
    case (k)
      0:       v[30:23] = 8'h00;
      1:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2:       begin v[30:23] = 8'hFF; v[22:0] = 23'($urandom_range(1, 32'h7FFFFF)); end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Waits from a negedge until done is seen; n returns the number of edges counted.
  task automatic wait_done(input int start_edge, output int n);
    n = start_edge;
    while (!done && n < start_edge + 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
    bit sp;
    int n;
    logic [31:0] e;
    exp_q.push_back(ref_div(x, y, sp));
    @(negedge clk); a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; a = $urandom; b = $urandom;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(1, n);
    chk({tag, "_lat"}, 64'(n), sp ? 64'd2 : 64'd28);
    e = exp_q.pop_front();
    chk({tag, "_res"}, 64'(result), 64'(e));
    @(negedge clk);
    chk({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int n, ndone;
    rst = 1'b1; start = 1'b0; start64 = 1'b0;
    a = '0; b = '0; a64 = '0; b64 = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_flags", {60'd0, busy, done, busy64, done64}, 64'd0);
    chk("rst_res64", result64, 64'd0);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, "six_by_two");
    chk("six_by_two_const", 64'(result), 64'h40400000);
    run_op(32'h3F800000, 32'h40400000, "third");
    chk("third_const", 64'(result), 64'h3EAAAAAA);
    run_op(32'hBF800000, 32'h00000000, "neg_div0");
    chk("neg_div0_const", 64'(result), 64'hFF800000);
    run_op(32'h00000000, 32'h00000000, "zero_zero");
    run_op(32'h7F800000, 32'h7F800000, "inf_inf");
    run_op(32'h3F800000, 32'hFF800000, "x_inf");
    run_op(32'h7F000000, 32'h00800000, "overflow");
    chk("overflow_const", 64'(result), 64'h7F800000);
    run_op(32'h00800000, 32'h7F000000, "underflow");
    run_op(32'hFF000000, 32'h00800000, "neg_overflow");

    // A second start mid-operation is ignored; a start held through DONE waits one edge.
    @(negedge clk); a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    n = 1;
    while (n < 9) begin @(posedge clk); n++; @(negedge clk); end
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); n++;
    @(negedge clk); start = 1'b0;
    wait_done(n, n);
    chk("hs_lat", 64'(n), 64'd28);
    chk("hs_res", 64'(result), 64'h40400000);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(1, n);
    start = 1'b0;
    chk("b2b_gap", 64'(n), 64'd29);
    chk("b2b_res", 64'(result), 64'h3EAAAAAA);
    @(negedge clk);

    // Reset at edge 15 of 6.0/2.0 aborts with no done pulse.
    @(negedge clk); a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_res", 64'(result), 64'd0);
    chk("abort_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(32'h40C00000, 32'h40000000, "after_abort");

    // Double precision 6.0/2.0.
    @(negedge clk); a64 = 64'h4018000000000000; b64 = 64'h4000000000000000; start64 = 1'b1;
    @(posedge clk);
    @(negedge clk); start64 = 1'b0;
    chk("d64_busy", 64'(busy64), 64'd1);
    n = 1;
    while (!done64 && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    chk("d64_lat", 64'(n), 64'd57);
    chk("d64_res", result64, 64'h4008000000000000);

    for (int i = 0; i < 60; i++) run_op(rnd_fp(), rnd_fp(), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
